// File: rtl/huc3_rtc_backup_seq.sv
// rtl/huc3_rtc_backup_seq.sv - HuC3 RTC backup load/save sequencer between host stream and mapper write port
module huc3_rtc_backup_seq #(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        load_start,
    input  logic        save_start,
    input  logic [15:0] host_wdata,
    input  logic        host_wvalid,
    output logic        host_wready,
    output logic [15:0] host_rdata,
    output logic        host_rvalid,
    input  logic        host_rready,
    input  logic [31:0] RTC_timestampOut,
    input  logic [47:0] RTC_savedtimeOut,
    output logic        bk_rtc_wr,
    output logic [16:0] bk_addr,
    output logic [15:0] bk_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_RECV, S_LD_CHECK, S_LD_WRITE, S_LD_GAP, S_SV_SEND, S_FIN
    } state_t;

    localparam logic [3:0]  GAP_LAST     = 4'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [2:0]  LAST_WORD    = 3'd4;
    localparam logic [2:0]  COMMIT_IDX   = 3'd5;

    state_t      state, state_nxt;
    logic [15:0] rec_buf [0:4];
    logic [2:0]  idx, widx;
    logic [15:0] timer;
    logic [3:0]  gap_cnt;
    logic        fin_ok, fin_ok_nxt;
    logic        range_bad;
    logic        timed_out;
    logic [5:0]  seconds;
    logic [11:0] minutes;

    function automatic logic [15:0] sel_word(input logic [2:0] i);
        logic [15:0] w;
        w = 16'd0;
        for (int k = 0; k < 5; k++)
            if (i == 3'(k)) w = rec_buf[k];
        return w;
    endfunction

    // savedtime = {buf4,buf3,buf2}; seconds in [5:0], minutes in [17:6]
    assign seconds   = rec_buf[2][5:0];
    assign minutes   = {rec_buf[3][1:0], rec_buf[2][15:6]};
    assign range_bad = (seconds > 6'd59) || (minutes > 12'd1439);
    assign timed_out = !host_wvalid && (timer == TIMEOUT_LAST);

    always_ff @(posedge clk_sys) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        fin_ok_nxt = 1'b0;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start)
                        state_nxt = S_LD_RECV;
                    else if (save_start)
                        state_nxt = S_SV_SEND;
                end
                S_LD_RECV: begin
                    if (host_wvalid && idx == LAST_WORD)
                        state_nxt = S_LD_CHECK;
                    else if (timed_out)
                        state_nxt = S_FIN;
                end
                S_LD_CHECK: state_nxt = range_bad ? S_FIN : S_LD_WRITE;
                S_LD_WRITE: begin
                    if (GAP != 0) begin
                        state_nxt = S_LD_GAP;
                    end else if (widx == COMMIT_IDX) begin
                        state_nxt  = S_FIN;
                        fin_ok_nxt = 1'b1;
                    end
                end
                S_LD_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (widx == COMMIT_IDX) begin
                            state_nxt  = S_FIN;
                            fin_ok_nxt = 1'b1;
                        end else begin
                            state_nxt = S_LD_WRITE;
                        end
                    end
                end
                S_SV_SEND: begin
                    if (host_rready && idx == LAST_WORD) begin
                        state_nxt  = S_FIN;
                        fin_ok_nxt = 1'b1;
                    end
                end
                S_FIN:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            idx     <= '0;
            widx    <= '0;
            timer   <= '0;
            gap_cnt <= '0;
            fin_ok  <= 1'b0;
            error   <= 1'b0;
        end else begin
            fin_ok <= fin_ok_nxt;
            if (enable) begin
                case (state)
                    S_IDLE: begin
                        if (load_start || save_start) begin
                            idx   <= '0;
                            timer <= '0;
                            error <= 1'b0;
                        end
                    end
                    S_LD_RECV: begin
                        if (host_wvalid) begin
                            idx   <= idx + 3'd1;
                            timer <= '0;
                        end else if (timed_out) begin
                            error <= 1'b1;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    S_LD_CHECK: begin
                        widx    <= '0;
                        gap_cnt <= '0;
                        if (range_bad)
                            error <= 1'b1;
                    end
                    S_LD_WRITE: begin
                        gap_cnt <= '0;
                        if (GAP == 0 && widx != COMMIT_IDX)
                            widx <= widx + 3'd1;
                    end
                    S_LD_GAP: begin
                        gap_cnt <= gap_cnt + 4'd1;
                        if (gap_cnt == GAP_LAST && widx != COMMIT_IDX)
                            widx <= widx + 3'd1;
                    end
                    S_SV_SEND: begin
                        if (host_rready)
                            idx <= idx + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Record buffer is deliberately left out of reset; the save snapshot is taken from one cycle's inputs
    always_ff @(posedge clk_sys) begin
        if (reset_n && enable) begin
            if (state == S_IDLE && !load_start && save_start) begin
                rec_buf[0] <= RTC_timestampOut[15:0];
                rec_buf[1] <= RTC_timestampOut[31:16];
                rec_buf[2] <= RTC_savedtimeOut[15:0];
                rec_buf[3] <= RTC_savedtimeOut[31:16];
                rec_buf[4] <= RTC_savedtimeOut[47:32];
            end else if (state == S_LD_RECV && host_wvalid) begin
                for (int k = 0; k < 5; k++)
                    if (idx == 3'(k))
                        rec_buf[k] <= host_wdata;
            end
        end
    end

    always_comb begin
        host_wready = 1'b0;
        host_rvalid = 1'b0;
        host_rdata  = 16'd0;
        bk_rtc_wr   = 1'b0;
        bk_addr     = 17'd0;
        bk_data     = 16'd0;
        busy        = (state != S_IDLE);
        done        = 1'b0;
        case (state)
            S_LD_RECV: host_wready = 1'b1;
            S_SV_SEND: begin
                host_rvalid = 1'b1;
                host_rdata  = sel_word(idx);
            end
            S_LD_WRITE, S_LD_GAP: begin
                bk_rtc_wr = (state == S_LD_WRITE);
                bk_addr   = {14'd0, widx};
                bk_data   = (widx == COMMIT_IDX) ? 16'd0 : sel_word(widx);
            end
            S_FIN:   done = fin_ok;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_huc3_rtc_backup_seq.sv
// tb/tb_huc3_rtc_backup_seq.sv - directed self-checking bench for huc3_rtc_backup_seq
module tb_huc3_rtc_backup_seq;

    logic        clk_sys = 1'b0;
    logic        reset_n, enable, load_start, save_start;
    logic [15:0] host_wdata;
    logic        host_wvalid, host_wready;
    logic [15:0] host_rdata;
    logic        host_rvalid, host_rready;
    logic [31:0] RTC_timestampOut;
    logic [47:0] RTC_savedtimeOut;
    logic        bk_rtc_wr;
    logic [16:0] bk_addr;
    logic [15:0] bk_data;
    logic        busy, done, error;

    always #5 clk_sys = ~clk_sys;

    huc3_rtc_backup_seq #(.GAP(2), .TIMEOUT(8)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable),
        .load_start(load_start), .save_start(save_start),
        .host_wdata(host_wdata), .host_wvalid(host_wvalid), .host_wready(host_wready),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_rready(host_rready),
        .RTC_timestampOut(RTC_timestampOut), .RTC_savedtimeOut(RTC_savedtimeOut),
        .bk_rtc_wr(bk_rtc_wr), .bk_addr(bk_addr), .bk_data(bk_data),
        .busy(busy), .done(done), .error(error)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    int          n_strb, done_cnt, done_cyc, err_cyc, wready_cnt, rvalid_cnt, busy_last;
    logic        err_c1;
    logic [16:0] s_addr [8];
    logic [15:0] s_data [8];
    int          s_cyc  [8];

    // Cycle 1 is the first cycle after the start edge; runs a fixed 40-cycle window
    task automatic run_load(input logic [79:0] w, input int n_give, input bit also_save, input int drop_after);
        int wi;
        n_strb = 0; done_cnt = 0; done_cyc = 0; err_cyc = 0;
        wready_cnt = 0; rvalid_cnt = 0; busy_last = 0;
        load_start = 1'b1;
        save_start = also_save;
        @(negedge clk_sys);
        load_start = 1'b0;
        save_start = 1'b0;
        err_c1 = error;
        wi = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bk_rtc_wr) begin
                if (n_strb < 8) begin
                    s_addr[n_strb] = bk_addr;
                    s_data[n_strb] = bk_data;
                    s_cyc[n_strb]  = cyc;
                end
                n_strb++;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (error && err_cyc == 0) err_cyc = cyc;
            if (host_wready) wready_cnt++;
            if (host_rvalid) rvalid_cnt++;
            if (busy) busy_last = cyc;
            if (drop_after > 0 && n_strb == drop_after) enable = 1'b0;
            if (wi < n_give && host_wready && enable) begin
                host_wdata  = w[wi*16 +: 16];
                host_wvalid = 1'b1;
                wi++;
            end else begin
                host_wvalid = 1'b0;
            end
            @(negedge clk_sys);
        end
        enable = 1'b1;
        host_wvalid = 1'b0;
    endtask

    task automatic run_save(input logic [31:0] ts, input logic [47:0] st, input logic [79:0] exp, input int stalls);
        int n_wr;
        n_wr = 0;
        RTC_timestampOut = ts;
        RTC_savedtimeOut = st;
        save_start = 1'b1;
        @(negedge clk_sys);
        save_start = 1'b0;
        RTC_timestampOut = ~ts;
        RTC_savedtimeOut = ~st;
        for (int w = 0; w < 5; w++) begin
            for (int s = 0; s <= stalls; s++) begin
                host_rready = (s == stalls);
                check($sformatf("sv_valid_w%0d", w), host_rvalid, 1);
                check($sformatf("sv_data_w%0d_s%0d", w, s), host_rdata, exp[w*16 +: 16]);
                if (bk_rtc_wr) n_wr++;
                @(negedge clk_sys);
            end
        end
        host_rready = 1'b0;
        check("sv_done", done, 1);
        check("sv_fin_busy", busy, 1);
        @(negedge clk_sys);
        check("sv_idle", {busy, done, host_rvalid}, 0);
        check("sv_no_wr", n_wr, 0);
    endtask

    logic [15:0] exp_d [6];

    initial begin
        reset_n = 1'b0; enable = 1'b1; load_start = 1'b0; save_start = 1'b0;
        host_wdata = '0; host_wvalid = 1'b0; host_rready = 1'b0;
        RTC_timestampOut = '0; RTC_savedtimeOut = '0;
        repeat (2) @(negedge clk_sys);
        check("rst_flags", {busy, done, error, bk_rtc_wr, host_wready, host_rvalid}, 0);
        check("rst_addr", bk_addr, 0);
        check("rst_data", {host_rdata, bk_data}, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Seconds 59, minutes 60; word3 bit2 is outside the checked minute field
        run_load(80'h0000_0004_0F3B_5678_1234, 5, 1'b0, 0);
        exp_d = '{16'h1234, 16'h5678, 16'h0F3B, 16'h0004, 16'h0000, 16'h0000};
        check("ld_nstrb", n_strb, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ld_addr%0d", i), s_addr[i], 17'(i));
            check($sformatf("ld_data%0d", i), s_data[i], exp_d[i]);
            check($sformatf("ld_cyc%0d", i), s_cyc[i], 7 + 3*i);
        end
        check("ld_done_cnt", done_cnt, 1);
        check("ld_done_cyc", done_cyc, 25);
        check("ld_no_err", err_cyc, 0);
        check("ld_busy_last", busy_last, 25);
        check("ld_wready_cnt", wready_cnt, 5);

        run_load(80'h0000_0000_003C_2222_1111, 5, 1'b0, 0);
        check("sec60_nstrb", n_strb, 0);
        check("sec60_done", done_cnt, 0);
        check("sec60_err_cyc", err_cyc, 7);
        check("sec60_busy_last", busy_last, 7);

        // Minutes exactly 1439 passes and the start clears the sticky error
        run_load(80'h0000_0001_67C0_2222_1111, 5, 1'b0, 0);
        check("min1439_err_clr", err_c1, 0);
        check("min1439_nstrb", n_strb, 6);
        check("min1439_done", done_cnt, 1);
        check("min1439_no_err", err_cyc, 0);

        run_load(80'h0000_0001_6800_2222_1111, 5, 1'b0, 0);
        check("min1440_nstrb", n_strb, 0);
        check("min1440_err_cyc", err_cyc, 7);

        run_load(80'h0000_0000_0000_BBBB_AAAA, 2, 1'b0, 0);
        check("to_wready_cnt", wready_cnt, 10);
        check("to_err_cyc", err_cyc, 11);
        check("to_busy_last", busy_last, 11);
        check("to_nstrb", n_strb, 0);
        check("to_done", done_cnt, 0);

        run_save(32'hDEADBEEF, 48'h0001_2345_6789, 80'h0001_2345_6789_DEAD_BEEF, 3);
        check("sv_err_clr", error, 0);

        run_load(80'h0000_0004_0F3B_5678_1234, 5, 1'b1, 3);
        check("drop_nstrb", n_strb, 3);
        check("drop_addr2", s_addr[2], 2);
        check("drop_busy_last", busy_last, 13);
        check("drop_done", done_cnt, 0);
        check("drop_no_save", rvalid_cnt, 0);

        RTC_timestampOut = 32'h1111_2222;
        RTC_savedtimeOut = 48'h3333_4444_5555;
        save_start = 1'b1;
        @(negedge clk_sys);
        save_start = 1'b0;
        host_rready = 1'b1;
        @(negedge clk_sys);
        reset_n = 1'b0;
        host_rready = 1'b0;
        @(negedge clk_sys);
        check("mid_rst_flags", {busy, done, error, bk_rtc_wr, host_wready, host_rvalid}, 0);
        check("mid_rst_data", {host_rdata, bk_data}, 0);
        check("mid_rst_addr", bk_addr, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        run_save(32'h0123_4567, 48'h89AB_CDEF_0123, 80'h89AB_CDEF_0123_0123_4567, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
